flag_scheduler: RTL and testbench

- Frame-synchronous controller that chooses which pride flag the shared pixel-colour mux shows.
- Sits between the hvsync generator and the flag-select mux in front of the combinational flag_* colour generators.
- Modes: timed auto-cycling, button-driven next/prev, and a manual-override hold window.
- flag_sel changes only at frame start, so a flag never switches mid-frame (no tearing).

---
 rtl/flag_scheduler_pkg.sv | 19 +
 rtl/flag_button_sync.sv | 26 ++
 rtl/flag_scheduler.sv | 142 ++++++++++++++
 tb/tb_flag_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/flag_scheduler_pkg.sv
// rtl/flag_scheduler_pkg.sv - shared state encodings, LFSR constants and defaults for flag_scheduler
package flag_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL   = 2'd0,
    ST_AUTO     = 2'd1,
    ST_OVERRIDE = 2'd2
  } fs_state_t;

  localparam int         DEF_NUM_FLAGS = 12;
  localparam logic [7:0] LFSR_SEED     = 8'hA5;
  // x^8+x^6+x^5+x^4+1 in right-shifting Galois form
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/flag_button_sync.sv
// rtl/flag_button_sync.sv - 2-flop button synchroniser with once-per-frame press detector
module flag_button_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  input  logic i_tick,
  output logic o_press
);
  logic r_s1, r_s2, r_frame;

  // Sampling only at frame ticks rejects any bounce shorter than a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (i_tick) r_frame <= r_s2;
    end
  end

  assign o_press = i_tick & r_s2 & ~r_frame;

endmodule

// File: rtl/flag_scheduler.sv
// rtl/flag_scheduler.sv - frame-synchronous flag selector: auto-cycle, next/prev buttons, override hold
// Optional shuffled auto-advance with FLAG_SCHED_SHUFFLE_EN.
module flag_scheduler
  import flag_scheduler_pkg::*;
#(
  parameter int   NUM_FLAGS       = DEF_NUM_FLAGS,
  parameter int   SEL_W           = 4,
  parameter int   HOLD_FRAMES     = 180,
  parameter int   OVERRIDE_FRAMES = 600,
  parameter logic VSYNC_POL       = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             auto_en,
  output logic [SEL_W-1:0] flag_sel,
  output logic             sel_changed,
  output logic [9:0]       hold_cnt
);
  logic             r_vs, r_vs_d, r_auto_s1, r_auto_s2;
  logic             w_tick, w_press_next, w_press_prev;
  logic             w_step_next, w_step_prev, w_press;
  fs_state_t        r_state, w_state_nx;
  logic [SEL_W-1:0] r_idx, w_idx_nx, w_idx_next, w_idx_prev, w_idx_btn, w_idx_auto;
  logic [9:0]       r_hold, w_hold_nx;
  logic             r_changed;

  // vsync regs reset to the active level so a reset released mid-pulse cannot fake a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs      <= VSYNC_POL;
      r_vs_d    <= VSYNC_POL;
      r_auto_s1 <= 1'b0;
      r_auto_s2 <= 1'b0;
    end else begin
      r_vs      <= vsync;
      r_vs_d    <= r_vs;
      r_auto_s1 <= auto_en;
      r_auto_s2 <= r_auto_s1;
    end
  end

  assign w_tick = (r_vs == VSYNC_POL) && (r_vs_d != VSYNC_POL);

  flag_button_sync u_btn_next (
    .clk(clk), .reset(reset), .i_btn(btn_next), .i_tick(w_tick), .o_press(w_press_next)
  );
  flag_button_sync u_btn_prev (
    .clk(clk), .reset(reset), .i_btn(btn_prev), .i_tick(w_tick), .o_press(w_press_prev)
  );

  // Both buttons in one frame cancel out
  assign w_step_next = w_press_next & ~w_press_prev;
  assign w_step_prev = w_press_prev & ~w_press_next;
  assign w_press     = w_step_next | w_step_prev;

  assign w_idx_next = (r_idx == SEL_W'(NUM_FLAGS - 1)) ? '0 : r_idx + SEL_W'(1);
  assign w_idx_prev = (r_idx == '0) ? SEL_W'(NUM_FLAGS - 1) : r_idx - SEL_W'(1);
  assign w_idx_btn  = w_step_next ? w_idx_next : (w_step_prev ? w_idx_prev : r_idx);

`ifdef FLAG_SCHED_SHUFFLE_EN
  logic [7:0]       r_lfsr;
  logic [SEL_W-1:0] w_cand_raw, w_cand;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_lfsr <= LFSR_SEED;
    else if (w_tick) r_lfsr <= lfsr_step(r_lfsr);
  end

  assign w_cand_raw = r_lfsr[SEL_W-1:0];
  assign w_cand     = (int'(w_cand_raw) >= NUM_FLAGS) ? w_cand_raw - SEL_W'(NUM_FLAGS) : w_cand_raw;
  assign w_idx_auto = (w_cand == r_idx) ? w_idx_next : w_cand;
`else
  assign w_idx_auto = w_idx_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_MANUAL;
      r_idx     <= '0;
      r_hold    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_hold    <= w_hold_nx;
      r_changed <= (w_idx_nx != r_idx);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_hold_nx  = r_hold;
    if (w_tick) begin
      if (!r_auto_s2) begin
        w_state_nx = ST_MANUAL;
        w_hold_nx  = '0;
        w_idx_nx   = w_idx_btn;
      end else begin
        case (r_state)
          ST_AUTO: begin
            // A press outranks an auto-advance due in the same frame
            if (w_press) begin
              w_state_nx = ST_OVERRIDE;
              w_idx_nx   = w_idx_btn;
              w_hold_nx  = '0;
            end else if (r_hold == 10'(HOLD_FRAMES - 1)) begin
              w_idx_nx  = w_idx_auto;
              w_hold_nx = '0;
            end else begin
              w_hold_nx = r_hold + 10'd1;
            end
          end
          ST_OVERRIDE: begin
            if (w_press) begin
              w_idx_nx  = w_idx_btn;
              w_hold_nx = '0;
            end else if (r_hold == 10'(OVERRIDE_FRAMES - 1)) begin
              w_state_nx = ST_AUTO;
              w_hold_nx  = '0;
            end else begin
              w_hold_nx = r_hold + 10'd1;
            end
          end
          default: begin
            w_state_nx = ST_AUTO;
            w_hold_nx  = '0;
            w_idx_nx   = w_idx_btn;
          end
        endcase
      end
    end
  end

  assign flag_sel    = r_idx;
  assign sel_changed = r_changed;
  assign hold_cnt    = r_hold;

endmodule

// File: tb/tb_flag_scheduler.sv
// tb/tb_flag_scheduler.sv - self-checking bench for flag_scheduler (FLAG_SCHED_SHUFFLE_EN aware)
module tb_flag_scheduler;
  localparam int NF = 12, SW = 4, HOLD = 4, OVR = 600, FLEN = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b1;
  logic          btn_next = 1'b0, btn_prev = 1'b0, auto_en = 1'b0;
  logic [SW-1:0] flag_sel;
  logic          sel_changed;
  logic [9:0]    hold_cnt;

  flag_scheduler #(
    .NUM_FLAGS(NF), .SEL_W(SW), .HOLD_FRAMES(HOLD), .OVERRIDE_FRAMES(OVR), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .btn_next(btn_next), .btn_prev(btn_prev),
    .auto_en(auto_en), .flag_sel(flag_sel), .sel_changed(sel_changed), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, n_chg = 0, c0 = 0, last_sel = 0;
  bit done = 1'b0, saw_wrap = 1'b0;
  // model: mode 0 manual, 1 auto, 2 override
  int m_mode, m_idx, m_hold, m_chg, m_lfsr;
  bit m_ln, m_lp;
`ifdef FLAG_SCHED_SHUFFLE_EN
  int seq0[200], seq1[200];
`endif

  task automatic check(string name, int got, int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_hold = 0; m_chg = 0; m_ln = 0; m_lp = 0; m_lfsr = 'hA5;
  endtask

  task automatic model_tick(bit n, bit p, bit a);
    int step, old, pick;
    step = ((n && !m_ln) ? 1 : 0) - ((p && !m_lp) ? 1 : 0);
    m_ln = n; m_lp = p;
    old  = m_idx;
    pick = (m_idx + 1) % NF;
`ifdef FLAG_SCHED_SHUFFLE_EN
    if ((m_lfsr % 16) % NF != m_idx) pick = (m_lfsr % 16) % NF;
    m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? 'hB8 : 0);
`endif
    if (!a) begin
      m_mode = 0; m_hold = 0; m_idx = (m_idx + step + NF) % NF;
    end else if (m_mode == 0) begin
      m_mode = 1; m_hold = 0; m_idx = (m_idx + step + NF) % NF;
    end else if (step != 0) begin
      m_mode = 2; m_hold = 0; m_idx = (m_idx + step + NF) % NF;
    end else if (m_mode == 1) begin
      if (m_hold == HOLD - 1) begin m_hold = 0; m_idx = pick; end
      else m_hold++;
    end else begin
      if (m_hold == OVR - 1) begin m_mode = 1; m_hold = 0; end
      else m_hold++;
    end
    m_chg = (m_idx != old) ? 1 : 0;
  endtask

  // One video frame; the tick lands two clocks after vsync falls at cycle 20
  task automatic frame(bit n, bit p, bit a, bit bounce, int rst_at);
    bit on, op;
    on = btn_next; op = btn_prev;
    for (int c = 0; c < FLEN; c++) begin
      @(negedge clk);
      if (c == 0) begin vsync = 1'b1; auto_en = a; end
      btn_next = (bounce && c < 9 && c % 2 == 1) ? on : n;
      btn_prev = (bounce && c < 9 && c % 2 == 1) ? op : p;
      if (c == rst_at) begin
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_sel", int'(flag_sel), 0);
        check("async_rst_hold", int'(hold_cnt), 0);
      end
      if (rst_at >= 0 && c == rst_at + 3) reset = 1'b0;
      if (c == 20) vsync = 1'b0;
      if (c == 21) model_tick(n, p, a);
      if (c == 22) m_chg = 0;
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (!done) begin
      check("flag_sel", int'(flag_sel), m_idx);
      check("sel_changed", int'(sel_changed), m_chg);
      check("hold_cnt", int'(hold_cnt), m_hold);
      if (sel_changed) begin
        n_chg++;
        if (last_sel == NF - 1 && int'(flag_sel) == 0) saw_wrap = 1'b1;
      end
      last_sel = int'(flag_sel);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_sel", int'(flag_sel), 0);
    check("rst_chg", int'(sel_changed), 0);
    check("rst_hold", int'(hold_cnt), 0);
    reset = 1'b0;

    // single bouncy press held three frames
    frame(0, 0, 0, 0, -1); frame(0, 0, 0, 0, -1);
    c0 = n_chg;
    frame(1, 0, 0, 1, -1); frame(1, 0, 0, 0, -1); frame(1, 0, 0, 0, -1);
    frame(0, 0, 0, 1, -1); frame(0, 0, 0, 0, -1);
    check("press_once", n_chg - c0, 1);
    check("press_sel", int'(flag_sel), 1);

`ifndef FLAG_SCHED_SHUFFLE_EN
    // auto cycling: entry frame then 12 advances, including the 11->0 wrap
    c0 = n_chg;
    repeat (49) frame(0, 0, 1, 0, -1);
    check("auto_adv_count", n_chg - c0, 12);
    check("auto_sel", int'(flag_sel), 1);
    check("auto_wrap", int'(saw_wrap), 1);

    // prev press at idx 0 in the frame an advance is due
    repeat (47) frame(0, 0, 1, 0, -1);
    check("pre_ovr_sel", int'(flag_sel), 0);
    check("pre_ovr_hold", int'(hold_cnt), 3);
    frame(0, 1, 1, 1, -1);
    check("ovr_sel", int'(flag_sel), 11);
    check("ovr_hold", int'(hold_cnt), 0);
    repeat (599) frame(0, 0, 1, 0, -1);
    check("ovr_hold_max", int'(hold_cnt), 599);
    check("ovr_no_adv", int'(flag_sel), 11);
    frame(0, 0, 1, 0, -1);
    check("ovr_exit_hold", int'(hold_cnt), 0);
    repeat (4) frame(0, 0, 1, 0, -1);
    check("resume_adv", int'(flag_sel), 0);

    // reach idx 7 in override, then reset mid-frame
    frame(1, 0, 1, 0, -1);
    repeat (6) begin frame(0, 0, 1, 0, -1); frame(1, 0, 1, 0, -1); end
    check("pre_rst_sel", int'(flag_sel), 7);
    frame(0, 0, 1, 0, 10);
    repeat (3) frame(0, 0, 1, 0, -1);
    check("post_rst_hold", int'(hold_cnt), 3);
    check("post_rst_sel", int'(flag_sel), 0);
    frame(0, 0, 1, 0, -1);
    check("post_rst_adv", int'(flag_sel), 1);
`endif

    // simultaneous next+prev at idx 5
    frame(0, 0, 0, 0, -1);
    repeat (4) begin frame(1, 0, 0, 0, -1); frame(0, 0, 0, 0, -1); end
    check("pre_both_sel", int'(flag_sel), 5);
    c0 = n_chg;
    frame(1, 1, 0, 1, -1); frame(1, 1, 0, 0, -1); frame(0, 0, 0, 1, -1);
    check("both_no_chg", n_chg - c0, 0);
    check("both_sel", int'(flag_sel), 5);

`ifdef FLAG_SCHED_SHUFFLE_EN
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      frame(0, 0, 1, 0, -1);
      for (int k = 0; k < 200; k++) begin
        repeat (HOLD) frame(0, 0, 1, 0, -1);
        if (r == 0) seq0[k] = int'(flag_sel);
        else        seq1[k] = int'(flag_sel);
      end
    end
    for (int k = 0; k < 200; k++) begin
      check("shuf_range", (seq0[k] < NF) ? 1 : 0, 1);
      if (k > 0) check("shuf_distinct", (seq0[k] != seq0[k-1]) ? 1 : 0, 1);
      check("shuf_repeat", seq1[k], seq0[k]);
    end
`endif

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
